fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the program_counter (drives its en/load/target) and the instruction-memory request/response port.
//  Delivers one fetched instruction at a time, with its PC, to decode over a valid/ready handshake.
//  Handles branch/jump redirects at any point in a fetch, including squashing in-flight memory responses.
//  Sits between program_counter, instruction memory and the decode stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded into program_counter in the first cycle after reset release
// PORTS
//  clk              in   1   single clock; all state changes on posedge
//  resetn           in   1   asynchronous, active-low reset
//  pc               in   32  current PC from program_counter
//  pc_en            out  1   program_counter enable
//  pc_load          out  1   program_counter load select (1 = pc_target, 0 = pc+4)
//  pc_target        out  32  program_counter load value
//  redirect         in   1   branch/jump taken this cycle
//  redirect_target  in   32  new PC when redirect=1
//  imem_req_valid   out  1   fetch request
//  imem_req_addr    out  32  fetch address (= pc)
//  imem_req_ready   in   1   memory accepts request this cycle
//  imem_resp_valid  in   1   response data valid (exactly one per accepted request, >=1 cycle later)
//  imem_resp_data   in   32  instruction word
//  instr_valid      out  1   instruction available to decode
//  instr            out  32  registered instruction word
//  instr_pc         out  32  registered PC of instr
//  instr_ready      in   1   decode accepts instr
// BEHAVIOUR
//  Reset (resetn=0, async): state=BOOT; instr_valid=0; instr=0; instr_pc=0. All outputs are low while in reset.
//  States: BOOT, REQ, WAIT, DRAIN, HOLD. The state and instr* outputs are registered; pc_* and imem_req_* are
//   combinational from state and inputs.
//  BOOT: pc_en=1, pc_load=1, pc_target=RESET_PC; always goes to REQ next cycle. redirect is ignored.
//  REQ: imem_req_valid=1, imem_req_addr=pc.
//   - ready=1 -> WAIT.
//   - ready=0 -> stay in REQ.
//   - Memory samples addr only on valid&ready; addr may change while stalled.
//  WAIT: on resp_valid, capture instr<=resp_data and instr_pc<=pc. In the same cycle pc_en=1, pc_load=0 (pc+4).
//   Then go to HOLD.
//  HOLD: instr_valid=1.
//   - instr_ready=1 -> REQ, and instr_valid=0 next cycle.
//   - Otherwise stay; instr and instr_pc are held stable.
//  DRAIN: waits for the squashed response. On resp_valid the data is discarded -> REQ.
//  Redirect (any state except BOOT): pc_en=1, pc_load=1, pc_target=redirect_target that cycle.
//   A load always wins over the pc+4 advance. Transitions:
//   - REQ with ready=1 -> DRAIN (the accepted request is squashed).
//   - REQ with ready=0 -> REQ (re-request at the new PC next cycle).
//   - WAIT with resp_valid=1 -> REQ (response discarded, no capture).
//   - WAIT with resp_valid=0 -> DRAIN.
//   - DRAIN -> DRAIN; resp_valid in the same cycle -> REQ.
//   - HOLD -> REQ with instr_valid=0 next cycle. If instr_ready=1 that same cycle, the handshake counts as
//     completed; otherwise the instruction is dropped.
//  When redirect=0 and no advance is due: pc_en=0, pc_load=0, pc_target=redirect_target (don't-care).
//  Throughput: at most 1 instruction per 3 cycles (REQ, WAIT, HOLD) with 0-wait memory; no pipelining.
//  Outstanding requests: never more than 1.
//  Address arithmetic: mod 2^32; PC 32'hFFFF_FFFC advances to 0 with no special handling.
//  Reset asserted mid-fetch: returns to BOOT. A late memory response after reset is the memory's responsibility;
//   the sequencer ignores resp_valid in BOOT and REQ.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds output ports fetch_count[31:0] and stall_count[31:0]. Both reset to 0 and wrap.
//   - fetch_count: +1 on each instr_valid & instr_ready handshake.
//   - stall_count: +1 each cycle in REQ with ready=0, in WAIT with resp_valid=0, or in DRAIN.
//  FETCH_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Reset release, RESET_PC=32'h100, 0-wait memory, instr_ready=1 -> instr_pc 100,104,108 in order;
//    instr_valid every 3rd cycle.
//  2 imem_req_ready=0 for 4 cycles in REQ -> req_valid is held; pc is unchanged; no instr_valid.
//  3 Redirect to 32'h200 in WAIT with resp 2 cycles later -> response discarded (DRAIN);
//    next instr_pc=32'h200.
//  4 HOLD with instr_ready=0 for 5 cycles -> instr and instr_pc are stable;
//    redirect then gives instr_valid=0 next cycle and fetch from the target.
//  5 Redirect and resp_valid in the same WAIT cycle -> no capture; pc=target; state REQ.
//  6 resetn pulsed low while in WAIT -> outputs clear immediately; BOOT reloads RESET_PC;
//    with FETCH_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives program_counter and the instruction-memory port, hands one instruction at a time to decode.
// Optional `FETCH_STATS_EN adds fetch_count / stall_count performance counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic        pc_load,
    output logic [31:0] pc_target,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HOLD} state_t;

    state_t state, state_nxt;
    logic   capture;

    always_comb begin
        state_nxt      = state;
        pc_en          = 1'b0;
        pc_load        = 1'b0;
        pc_target      = redirect_target;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc;
        capture        = 1'b0;

        case (state)
            BOOT: begin
                pc_en     = 1'b1;
                pc_load   = 1'b1;
                pc_target = RESET_PC;
                state_nxt = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (redirect)
                    state_nxt = imem_req_ready ? DRAIN : REQ;
                else if (imem_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (redirect)
                    state_nxt = imem_resp_valid ? REQ : DRAIN;
                else if (imem_resp_valid) begin
                    capture   = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            DRAIN: begin
                if (imem_resp_valid)
                    state_nxt = REQ;
            end
            HOLD: begin
                if (redirect || instr_ready)
                    state_nxt = REQ;
            end
            default: state_nxt = BOOT;
        endcase

        // A redirect load overrides any pc+4 advance requested above.
        if (redirect && state != BOOT) begin
            pc_en     = 1'b1;
            pc_load   = 1'b1;
            pc_target = redirect_target;
        end

        if (!resetn) begin
            pc_en          = 1'b0;
            pc_load        = 1'b0;
            pc_target      = 32'h0;
            imem_req_valid = 1'b0;
            imem_req_addr  = 32'h0;
            capture        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= BOOT;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            state       <= state_nxt;
            instr_valid <= (state_nxt == HOLD);
            if (capture) begin
                instr    <= imem_resp_data;
                instr_pc <= pc;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic stall;

    assign stall = (state == REQ  && !imem_req_ready)  ||
                   (state == WAIT && !imem_resp_valid) ||
                   (state == DRAIN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (instr_valid && instr_ready)
                fetch_count <= fetch_count + 32'd1;
            if (stall)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC register and memory models around the DUT, expected PCs queued per fetch.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic        pc_en, pc_load;
    logic [31:0] pc_target;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        mem_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        instr_ready;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          mem_lat = 0;
    int          hs_cyc[$];
    logic [31:0] exp_q[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pc              (pc),
        .pc_en           (pc_en),
        .pc_load         (pc_load),
        .pc_target       (pc_target),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (mem_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h3C00_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // program_counter model
    always @(posedge clk or negedge resetn) begin
        if (!resetn)
            pc <= 32'h0;
        else if (pc_en)
            pc <= pc_load ? pc_target : pc + 32'd4;
    end

    // Instruction memory: one response per accepted request, mem_lat extra cycles late.
    logic        pend;
    int          cnt;
    logic [31:0] addr_q;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend            <= 1'b0;
            cnt             <= 0;
            addr_q          <= 32'h0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= 32'h0;
        end else begin
            imem_resp_valid <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_word(addr_q);
                    pend            <= 1'b0;
                end else
                    cnt <= cnt - 1;
            end
            if (imem_req_valid && mem_ready) begin
                check_val("one_outstanding", {31'b0, pend}, 32'h0);
                if (mem_lat == 0) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_word(imem_req_addr);
                end else begin
                    pend   <= 1'b1;
                    cnt    <= mem_lat;
                    addr_q <= imem_req_addr;
                end
            end
        end
    end

    // Decode-side monitor: every handshake pops the scoreboard.
    always @(negedge clk) begin
        if (resetn && instr_valid && instr_ready) begin
            logic [31:0] e;
            hs_count++;
            hs_cyc.push_back(cyc);
            check_val("sb_depth", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("sb_instr_pc", instr_pc, e);
                check_val("sb_instr", instr, mem_word(e));
            end
        end
    end

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_count < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check_val("hs_count", 32'(hs_count), 32'(n));
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!instr_valid && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check_val("instr_valid_seen", {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 instr_ready = 1'b1;
        @(posedge clk); #1 instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        mem_ready = 1'b1; instr_ready = 1'b1; mem_lat = 0;
        #2 resetn = 1'b0;
        #1;
        check_val("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_instr_pc", instr_pc, 32'h0);
        check_val("rst_pc_en", {31'b0, pc_en}, 32'h0);
        check_val("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);

        // Boot at 0x100 with zero-wait memory, decode always ready
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk); #1;
        check_val("boot_pc_target", pc_target, 32'h100);
        check_val("boot_pc_load", {31'b0, pc_load}, 32'h1);
        wait_hs(3, 40);
        check_val("rate_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
        check_val("rate_1_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
        @(posedge clk); #1 instr_ready = 1'b0; mem_ready = 1'b0;
`ifdef FETCH_STATS_EN
        check_val("stats_fetch_t1", fetch_count, 32'd3);
        check_val("stats_stall_t1", stall_count, 32'd0);
`endif

        // Memory stalls the request for 4 cycles
        repeat (4) begin
            @(negedge clk); #1;
            check_val("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
            check_val("stall_req_addr", imem_req_addr, 32'h10C);
            check_val("stall_pc", pc, 32'h10C);
            check_val("stall_instr_valid", {31'b0, instr_valid}, 32'h0);
        end
        @(posedge clk); #1 mem_ready = 1'b1; mem_lat = 2;
`ifdef FETCH_STATS_EN
        check_val("stats_stall_t2", stall_count, 32'd4);
`endif

        // Redirect while waiting; late response must be drained
        @(posedge clk); #1 redirect = 1'b1; redirect_target = 32'h200;
        @(negedge clk); #1;
        check_val("wait_redir_en", {31'b0, pc_en}, 32'h1);
        check_val("wait_redir_load", {31'b0, pc_load}, 32'h1);
        check_val("wait_redir_target", pc_target, 32'h200);
        @(posedge clk); #1 redirect = 1'b0;
        check_val("wait_redir_pc", pc, 32'h200);
        check_val("drain_no_req", {31'b0, imem_req_valid}, 32'h0);
        wait_valid(20);
        check_val("drain_instr_pc", instr_pc, 32'h200);
        check_val("drain_instr", instr, mem_word(32'h200));

        // Decode back-pressure holds the instruction
        repeat (5) begin
            @(negedge clk); #1;
            check_val("hold_valid", {31'b0, instr_valid}, 32'h1);
            check_val("hold_instr_pc", instr_pc, 32'h200);
            check_val("hold_instr", instr, mem_word(32'h200));
        end
        exp_q.push_back(32'h200);
        pulse_ready();
        wait_valid(20);
        check_val("hold2_instr_pc", instr_pc, 32'h204);
        @(posedge clk); #1 redirect = 1'b1; redirect_target = 32'h300;
        @(negedge clk); #1;
        check_val("hold_redir_target", pc_target, 32'h300);
        @(posedge clk); #1 redirect = 1'b0; mem_lat = 0;
        check_val("hold_redir_valid", {31'b0, instr_valid}, 32'h0);
        check_val("hold_redir_req", {31'b0, imem_req_valid}, 32'h1);
        check_val("hold_redir_addr", imem_req_addr, 32'h300);

        // Redirect coincides with the response: no capture
        @(posedge clk); #1 redirect = 1'b1; redirect_target = 32'h400;
        @(negedge clk); #1;
        check_val("same_cyc_load", {31'b0, pc_load}, 32'h1);
        check_val("same_cyc_target", pc_target, 32'h400);
        @(posedge clk); #1 redirect = 1'b0;
        check_val("same_cyc_req", {31'b0, imem_req_valid}, 32'h1);
        check_val("same_cyc_pc", pc, 32'h400);
        check_val("same_cyc_valid", {31'b0, instr_valid}, 32'h0);
        check_val("same_cyc_nocap", instr_pc, 32'h204);
        exp_q.push_back(32'h400);
        wait_valid(20);
        pulse_ready();
        mem_lat = 3;

        // Reset in the middle of a fetch
        @(posedge clk); #1;
`ifdef FETCH_STATS_EN
        check_val("stats_fetch_pre_rst", fetch_count, 32'd5);
`endif
        resetn = 1'b0;
        #1;
        check_val("rst2_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_val("rst2_instr", instr, 32'h0);
        check_val("rst2_instr_pc", instr_pc, 32'h0);
        check_val("rst2_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check_val("rst2_pc_en", {31'b0, pc_en}, 32'h0);
`ifdef FETCH_STATS_EN
        check_val("rst2_fetch_count", fetch_count, 32'd0);
        check_val("rst2_stall_count", stall_count, 32'd0);
`endif
        mem_lat = 0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk); #1;
        check_val("boot2_pc_en", {31'b0, pc_en}, 32'h1);
        check_val("boot2_pc_target", pc_target, 32'h100);
        @(posedge clk); #1;
        check_val("boot2_pc", pc, 32'h100);
        check_val("boot2_req_addr", imem_req_addr, 32'h100);

        // Redirect in a stalled request, then wrap past 0xFFFFFFFC
        mem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(posedge clk); #1 redirect = 1'b0;
        check_val("req_redir_valid", {31'b0, imem_req_valid}, 32'h1);
        check_val("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        n = hs_count + 2;
        mem_ready = 1'b1; instr_ready = 1'b1;
        wait_hs(n, 40);
        @(posedge clk); #1 instr_ready = 1'b0;

        // Redirect on an accepted request squashes it
        redirect = 1'b1; redirect_target = 32'h500; mem_lat = 1;
        @(posedge clk); #1 redirect = 1'b0;
        check_val("squash_no_req", {31'b0, imem_req_valid}, 32'h0);
        check_val("squash_pc", pc, 32'h500);
        exp_q.push_back(32'h500);
        wait_valid(20);
        pulse_ready();
        check_val("sb_drained", 32'(exp_q.size()), 32'h0);
`ifdef FETCH_STATS_EN
        check_val("stats_fetch_end", fetch_count, 32'd3);
        check_val("stats_stall_end", stall_count, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
